// File: rtl/ncl_pkg.sv
// Shared dual-rail (NCL) pair codes, link state type and pair helpers for the
// clocked dual-rail adder.
package ncl_pkg;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_0    = 2'b01;
    localparam logic [1:0] DR_1    = 2'b10;
    localparam logic [1:0] DR_ILL  = 2'b11;

    typedef enum logic {
        LNULL = 1'b0,
        LDATA = 1'b1
    } link_state_e;

    function automatic logic dr_complete(input logic [1:0] p);
        return (p == DR_0) || (p == DR_1);
    endfunction

    function automatic logic dr_allnull(input logic [1:0] p);
        return (p == DR_NULL);
    endfunction

    function automatic logic [1:0] dr_encode(input logic v);
        return v ? DR_1 : DR_0;
    endfunction

    // Only valid for legal DATA pairs; NULL and illegal decode as 0.
    function automatic logic dr_decode(input logic [1:0] p);
        return (p == DR_1);
    endfunction

endpackage

// File: rtl/ncl_dr_link.sv
// One hysteresis output link: captures encoded DATA on a COMPLETE wavefront
// while downstream requests DATA, and returns to NULL on an ALLNULL wavefront.
module ncl_dr_link
    import ncl_pkg::*;
#(
    parameter int N = 1
) (
    input  logic           clk,
    input  logic           init_n,
    input  logic           in_complete,
    input  logic           in_allnull,
    input  logic           comp,
    input  logic [N-1:0]   data,
    output logic [2*N-1:0] dr,
    output logic           is_data,
    output logic           is_null
);

    link_state_e      state_q, state_d;
    logic [2*N-1:0]   dr_q, dr_d;
    logic [2*N-1:0]   dr_enc;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_enc
            assign dr_enc[2*gi +: 2] = dr_encode(data[gi]);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        dr_d    = dr_q;
        case (state_q)
            LNULL: begin
                if (in_complete && !comp) begin
                    state_d = LDATA;
                    dr_d    = dr_enc;
                end
            end
            LDATA: begin
                if (in_allnull && comp) begin
                    state_d = LNULL;
                    dr_d    = '0;
                end
            end
            default: begin
                state_d = LNULL;
                dr_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= LNULL;
            dr_q    <= '0;
        end else begin
            state_q <= state_d;
            dr_q    <= dr_d;
        end
    end

    assign dr      = dr_q;
    assign is_data = (state_q == LDATA);
    assign is_null = (state_q == LNULL);

endmodule

// File: rtl/ncl_addn_dr.sv
// Clocked WIDTH-bit dual-rail adder with independent sum/cout NCL links and a
// registered TH22 completion back to upstream. Option: NCL_ADD_CODE_CHECK_EN.
module ncl_addn_dr
    import ncl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    input  logic [1:0]         cin,
    output logic               in_comp,
    output logic [2*WIDTH-1:0] sum,
    input  logic               sum_comp,
    output logic [1:0]         cout,
    input  logic               cout_comp,
    output logic               err
);

    localparam int NP = 2*WIDTH + 1;

    logic [2*NP-1:0] pairs;
    logic [NP-1:0]   pair_ok;
    logic [NP-1:0]   pair_null;
    logic [WIDTH-1:0] a_bin, b_bin;
    logic            cin_bin;
    logic            in_complete, in_allnull;
    logic [WIDTH:0]  sum_full;

    assign pairs = {cin, b, a};

    // Illegal 11 pairs fail both tests, so they always classify as PARTIAL.
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_class
            assign pair_ok[gi]   = dr_complete(pairs[2*gi +: 2]);
            assign pair_null[gi] = dr_allnull(pairs[2*gi +: 2]);
        end
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign a_bin[gi] = dr_decode(a[2*gi +: 2]);
            assign b_bin[gi] = dr_decode(b[2*gi +: 2]);
        end
    endgenerate

    assign cin_bin     = dr_decode(cin);
    assign in_complete = &pair_ok;
    assign in_allnull  = &pair_null;
    assign sum_full    = {1'b0, a_bin} + {1'b0, b_bin} + {{WIDTH{1'b0}}, cin_bin};

    logic sum_is_data, sum_is_null;
    logic cout_is_data, cout_is_null;

    ncl_dr_link #(.N(WIDTH)) u_sum_link (
        .clk         (clk),
        .init_n      (init_n),
        .in_complete (in_complete),
        .in_allnull  (in_allnull),
        .comp        (sum_comp),
        .data        (sum_full[WIDTH-1:0]),
        .dr          (sum),
        .is_data     (sum_is_data),
        .is_null     (sum_is_null)
    );

    ncl_dr_link #(.N(1)) u_cout_link (
        .clk         (clk),
        .init_n      (init_n),
        .in_complete (in_complete),
        .in_allnull  (in_allnull),
        .comp        (cout_comp),
        .data        (sum_full[WIDTH]),
        .dr          (cout),
        .is_data     (cout_is_data),
        .is_null     (cout_is_null)
    );

    logic in_comp_q, in_comp_d;

    always_comb begin
        in_comp_d = in_comp_q;
        if (sum_is_data && cout_is_data) begin
            in_comp_d = 1'b1;
        end else if (sum_is_null && cout_is_null) begin
            in_comp_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            in_comp_q <= 1'b0;
        end else begin
            in_comp_q <= in_comp_d;
        end
    end

    assign in_comp = in_comp_q;

`ifdef NCL_ADD_CODE_CHECK_EN
    logic [NP-1:0] pair_ill;
    logic          err_q, err_d;

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_ill
            assign pair_ill[gi] = (pairs[2*gi +: 2] == DR_ILL);
        end
    endgenerate

    always_comb begin
        err_d = err_q | (|pair_ill);
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
